ccd_burst_reader: RTL and testbench
===================================

# ccd_burst_reader

Synthesizable consumer-side engine for the clock-domain-crossing FIFO. It runs in the consumer clock domain and drains a burst of `BURST_LEN` words through the FIFO read port, honouring `EMPTY`. It inserts `RD_IDLE` gap cycles between reads and checks every word against the producer's ramp pattern `(P_SEED + i)`. It is the RTL counterpart of the producer that writes the ramp, and reports word count, error count, first failing index and completion.

## Interface
- `P_DATA_WIDTH`, 8, FIFO word width.
- `P_MAX_BURST`, 1024, largest burst; `CNT_W = $clog2(P_MAX_BURST+1)` (11 at default).
- `P_IDLE_W`, 4, width of `RD_IDLE`.
- `P_SEED`, 1, expected value of word 0.
- `CON_CLK`  in  1  consumer clock; all logic is on its rising edge.
- `RST_n`  in  1  reset, synchronous, active-low.
- `START`  in  1  one-cycle request to begin a burst; ignored unless idle.
- `BURST_LEN`  in  CNT_W  words to read; sampled when `START` is accepted.
- `RD_IDLE`  in  P_IDLE_W  gap cycles after each accepted read; sampled with `BURST_LEN`.
- `EMPTY`  in  1  FIFO empty flag.
- `DATA_IN`  in  P_DATA_WIDTH  FIFO read data, valid the cycle after an accepted read.
- `R_EN`  out  1  read request, combinational: `(state==S_READ) && !EMPTY`.
- `BUSY`  out  1  burst in progress.
- `DONE`  out  1  one-cycle completion pulse.
- `WORD_CNT`  out  CNT_W  words received this burst.
- `ERR_CNT`  out  CNT_W  mismatching words; saturates at all-ones.
- `ERR_FLAG`  out  1  at least one mismatch this burst.
- `FIRST_ERR_IDX`  out  CNT_W  index of the first mismatch; valid when `ERR_FLAG` is set.
- `LAST_DATA`  out  P_DATA_WIDTH  most recent word received.

## Operation
- **States:** `S_IDLE`, `S_READ`, `S_GAP`, `S_DRAIN`.
- **Accept condition:** a read is accepted on a rising edge where `R_EN` is high. `R_EN` already excludes `EMPTY`.
- **S_IDLE:**
  - `START` with `BURST_LEN>0` latches `BURST_LEN`/`RD_IDLE`, clears all counters and flags, sets `BUSY`, and goes to `S_READ`.
  - `START` with `BURST_LEN==0` pulses `DONE` next cycle, leaves counters cleared, stays idle, and never reads.
- **S_READ:** on accept, `issued++`.
  - If `issued` reaches the latched length, go to `S_DRAIN`.
  - Otherwise, if the latched `RD_IDLE>0`, go to `S_GAP` with `gap_cnt=RD_IDLE`.
  - Otherwise stay in `S_READ`.
  - `EMPTY` high: stay, `R_EN` low.
- **S_GAP:** decrement `gap_cnt`; go to `S_READ` when it reaches 1. `R_EN` is low throughout.
- **Check stage:** `vld_q` is the registered accept.
  - When `vld_q` is set: compare `DATA_IN` with `(P_SEED + WORD_CNT) mod 2^P_DATA_WIDTH`, then `WORD_CNT++` and `LAST_DATA<=DATA_IN`.
  - On mismatch: `ERR_CNT++` (saturating). If `ERR_FLAG` is clear, set it and capture `FIRST_ERR_IDX<=WORD_CNT`.
- **S_DRAIN:** wait for the final check. On the edge where `WORD_CNT` becomes the latched length:
  - go to `S_IDLE`;
  - `BUSY<=0`, `DONE<=1` for one cycle.
- **After completion:** counters hold until the next accepted `START`.
- **START while BUSY:** ignored; no state or counter change.
- **Reset:** `RST_n` low at any edge, including mid-burst, forces `S_IDLE`. All outputs and internal counters go to 0. `R_EN` is low in the following cycle. A pending in-flight word is discarded.

## Timing
- **Reset values:** `R_EN=0`, `BUSY=0`, `DONE=0`, and `WORD_CNT`, `ERR_CNT`, `ERR_FLAG`, `FIRST_ERR_IDX`, `LAST_DATA` all 0.
- **First read:** `START` sampled at edge n makes `BUSY=1` and `S_READ` from n. The first `R_EN` can occur in cycle n→n+1.
- **Read latency:** an accept at edge k has its data checked at edge k+1, where `WORD_CNT` updates.
- **Throughput:** one read per `(1+RD_IDLE)` cycles when non-empty. With `RD_IDLE=0`, reads are back-to-back.
- **Completion:** for a final accept at edge k, `DONE` is high and `BUSY` low after edge k+1. Burst duration with no empty stalls is `L*(1+RD_IDLE) - RD_IDLE + 1` cycles from `START` to `DONE`.
- **Pattern wrap:** the expected value wraps modulo `2^P_DATA_WIDTH`, so word 255 expects 0 at width 8 with seed 1.
- **EMPTY:** sampled combinationally each cycle. Deassertion mid-`S_READ` allows a read in the same cycle.

## Structure
- Add to `ccd_pkg`:
  - `typedef enum logic [1:0] {S_IDLE,S_READ,S_GAP,S_DRAIN} rd_state_e`;
  - function `exp_word(seed, idx)` returning the wrapped ramp value, shared with the producer model.
- Sub-module `ccd_rd_checker` holds the `vld_q` compare stage, `WORD_CNT`/`ERR_CNT`/`ERR_FLAG`/`FIRST_ERR_IDX`/`LAST_DATA`. The top module holds the FSM, issue counter and gap counter.

## Test plan
- **Clean burst:** reset, `START` with `BURST_LEN=16`, `RD_IDLE=0`, FIFO model preloaded with 1..16 -> 16 consecutive `R_EN` cycles, `WORD_CNT=16`, `ERR_CNT=0`, single `DONE` 1 cycle after the last data.
- **Gap spacing:** `BURST_LEN=8`, `RD_IDLE=2`, FIFO never empty -> `R_EN` exactly every 3rd cycle, `DONE` 23 cycles after `START`.
- **Empty stalls:** `EMPTY` high for 5 cycles after the 3rd read of a 10-word burst -> no `R_EN` while empty, reads resume on the cycle `EMPTY` falls, `WORD_CNT=10`, no errors.
- **Corruption:** word index 4 forced to 0xAA and index 9 to 0x00 in a 12-word burst -> `ERR_CNT=2`, `ERR_FLAG=1`, `FIRST_ERR_IDX=4`.
- **Boundaries:** `BURST_LEN=0` -> `DONE` pulse, no `R_EN`. `BURST_LEN=1024` with seed 1 -> wrap checked at index 255 (expects 0x00), `ERR_CNT=0`. `START` during `BUSY` ignored.
- **Reset mid-burst:** `RST_n` low for 1 cycle after 5 of 20 reads -> all outputs 0 next cycle, `R_EN` low. A new 4-word `START` then completes normally.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared types and helpers for the clock-domain-crossing FIFO test engines.
package ccd_pkg;

  // Consumer-side burst reader states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_GAP,
    S_DRAIN
  } rd_state_e;

  // Default geometry shared by the producer and consumer engines.
  localparam int CCD_DATA_WIDTH = 8;
  localparam int CCD_MAX_BURST  = 1024;

  // Ramp value expected at word idx. Callers keep only the low word-width
  // bits, and that truncation is what makes the pattern wrap.
  function automatic logic [31:0] exp_word(input logic [31:0] seed, input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/ccd_rd_checker.sv
// Check stage of the burst reader: compares each returned FIFO word with the
// ramp pattern and keeps the per-burst statistics.
module ccd_rd_checker
  import ccd_pkg::*;
#(
  parameter int P_DATA_WIDTH = CCD_DATA_WIDTH,
  parameter int P_SEED       = 1,
  parameter int CNT_W        = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [P_DATA_WIDTH-1:0] data_in,
  output logic                    check_vld,
  output logic [CNT_W-1:0]        word_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    err_flag,
  output logic [CNT_W-1:0]        first_err_idx,
  output logic [P_DATA_WIDTH-1:0] last_data
);

  logic [P_DATA_WIDTH-1:0] exp_data;
  logic                    mismatch;

  // Expected ramp word for the word currently being returned.
  always_comb begin
    exp_data = P_DATA_WIDTH'(exp_word(32'(P_SEED), 32'(word_cnt)));
    mismatch = (data_in != exp_data);
  end

  // Data arrives one cycle after the read is accepted, so the accept is
  // delayed by a register and the returned word is scored on the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      check_vld     <= 1'b0;
      word_cnt      <= '0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      last_data     <= '0;
    end else begin
      check_vld <= accept;
      if (clear) begin
        word_cnt      <= '0;
        err_cnt       <= '0;
        err_flag      <= 1'b0;
        first_err_idx <= '0;
        last_data     <= '0;
      end else if (check_vld) begin
        word_cnt  <= word_cnt + 1'b1;
        last_data <= data_in;
        if (mismatch) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (!err_flag) begin
            err_flag      <= 1'b1;
            first_err_idx <= word_cnt;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ccd_burst_reader.sv
// Consumer-domain burst reader: drains BURST_LEN words from the CDC FIFO with
// RD_IDLE gap cycles between reads and checks them against the producer ramp.
module ccd_burst_reader
  import ccd_pkg::*;
#(
  parameter int  P_DATA_WIDTH = CCD_DATA_WIDTH,
  parameter int  P_MAX_BURST  = CCD_MAX_BURST,
  parameter int  P_IDLE_W     = 4,
  parameter int  P_SEED       = 1,
  localparam int CNT_W        = $clog2(P_MAX_BURST + 1)
) (
  input  logic                    CON_CLK,
  input  logic                    RST_n,
  input  logic                    START,
  input  logic [CNT_W-1:0]        BURST_LEN,
  input  logic [P_IDLE_W-1:0]     RD_IDLE,
  input  logic                    EMPTY,
  input  logic [P_DATA_WIDTH-1:0] DATA_IN,
  output logic                    R_EN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CNT_W-1:0]        WORD_CNT,
  output logic [CNT_W-1:0]        ERR_CNT,
  output logic                    ERR_FLAG,
  output logic [CNT_W-1:0]        FIRST_ERR_IDX,
  output logic [P_DATA_WIDTH-1:0] LAST_DATA
);

  rd_state_e             state, state_n;
  logic [CNT_W-1:0]      issued, issued_n;
  logic [CNT_W-1:0]      len_q, len_n;
  logic [P_IDLE_W-1:0]   idle_q, idle_n;
  logic [P_IDLE_W-1:0]   gap_cnt, gap_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  clear;
  logic                  rd_en;
  logic                  check_vld;
  logic [CNT_W-1:0]      word_cnt;

  // Next-state logic: read issue, gap spacing and waiting for the last check.
  always_comb begin
    state_n  = state;
    issued_n = issued;
    len_n    = len_q;
    idle_n   = idle_q;
    gap_n    = gap_cnt;
    busy_n   = busy_q;
    done_n   = 1'b0;
    clear    = 1'b0;
    rd_en    = (state == S_READ) && !EMPTY;
    case (state)
      S_IDLE: begin
        if (START) begin
          clear    = 1'b1;
          issued_n = '0;
          if (BURST_LEN != '0) begin
            len_n   = BURST_LEN;
            idle_n  = RD_IDLE;
            busy_n  = 1'b1;
            state_n = S_READ;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_READ: begin
        if (rd_en) begin
          issued_n = issued + 1'b1;
          if (issued_n == len_q) begin
            state_n = S_DRAIN;
          end else if (idle_q != '0) begin
            gap_n   = idle_q;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_n = gap_cnt - 1'b1;
        if (gap_cnt <= P_IDLE_W'(1)) begin
          state_n = S_READ;
        end
      end
      S_DRAIN: begin
        if (check_vld && ((word_cnt + 1'b1) == len_q)) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any burst in progress.
  always_ff @(posedge CON_CLK) begin
    if (!RST_n) begin
      state   <= S_IDLE;
      issued  <= '0;
      len_q   <= '0;
      idle_q  <= '0;
      gap_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      issued  <= issued_n;
      len_q   <= len_n;
      idle_q  <= idle_n;
      gap_cnt <= gap_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  ccd_rd_checker #(
    .P_DATA_WIDTH(P_DATA_WIDTH),
    .P_SEED      (P_SEED),
    .CNT_W       (CNT_W)
  ) u_checker (
    .clk          (CON_CLK),
    .rst_n        (RST_n),
    .clear        (clear),
    .accept       (rd_en),
    .data_in      (DATA_IN),
    .check_vld    (check_vld),
    .word_cnt     (word_cnt),
    .err_cnt      (ERR_CNT),
    .err_flag     (ERR_FLAG),
    .first_err_idx(FIRST_ERR_IDX),
    .last_data    (LAST_DATA)
  );

  assign R_EN     = rd_en;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign WORD_CNT = word_cnt;

endmodule

// File: tb/tb_ccd_burst_reader.sv
// Self-checking bench for ccd_burst_reader with a behavioural FIFO and a
// ramp-pattern reference model.
module tb_ccd_burst_reader;

  localparam int SEED = 1;

  logic        clk;
  logic        rst_n;
  logic        start_s;
  logic [10:0] burst_len_s;
  logic [3:0]  rd_idle_s;
  logic        empty_s;
  logic [7:0]  data_in;
  logic        r_en_o;
  logic        busy_o;
  logic        done_o;
  logic [10:0] wc_o;
  logic [10:0] ec_o;
  logic        ef_o;
  logic [10:0] fe_o;
  logic [7:0]  ld_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] words[$];
  logic [7:0] fifo_q[$];
  int         acc_times[$];
  int         cyc = 0;
  int         acc_count = 0;
  int         ren_viol = 0;
  bit         pend = 0;
  int         stall_left = 0;
  int         stall_after_cfg = 0;
  int         stall_len_cfg = 0;
  bit         stall_armed = 0;

  typedef struct {
    string name;
    int len;
    int idle;
    int c0i;
    int c0v;
    int c1i;
    int c1v;
    int st_after;
    int st_len;
    int restart;
    int wc;
    int err;
    int flag;
    int fe;
    int dur;
  } vec_t;

  vec_t vecs[8];

  ccd_burst_reader dut (
    .CON_CLK      (clk),
    .RST_n        (rst_n),
    .START        (start_s),
    .BURST_LEN    (burst_len_s),
    .RD_IDLE      (rd_idle_s),
    .EMPTY        (empty_s),
    .DATA_IN      (data_in),
    .R_EN         (r_en_o),
    .BUSY         (busy_o),
    .DONE         (done_o),
    .WORD_CNT     (wc_o),
    .ERR_CNT      (ec_o),
    .ERR_FLAG     (ef_o),
    .FIRST_ERR_IDX(fe_o),
    .LAST_DATA    (ld_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read monitor: logs every accepted read and flags reads issued while empty.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (r_en_o) begin
      acc_count = acc_count + 1;
      acc_times.push_back(cyc);
      pend = 1'b1;
      if (empty_s) ren_viol = ren_viol + 1;
    end
  end

  // FIFO model: returns popped data in the cycle after the read and drives
  // EMPTY from its occupancy plus any injected stall window.
  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
    end
    if (stall_left > 0) stall_left = stall_left - 1;
    if (stall_armed && acc_count == stall_after_cfg) begin
      stall_armed = 1'b0;
      stall_left  = stall_len_cfg;
    end
    empty_s = (fifo_q.size() == 0) || (stall_left > 0);
  end

  task automatic checkOutput(input string tag, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic buildWords(input int len, input int c0i, input int c0v, input int c1i, input int c1v);
    words.delete();
    for (int i = 0; i < len; i++) words.push_back(8'((SEED + i) % 256));
    if (c0i >= 0 && c0i < len) words[c0i] = 8'(c0v);
    if (c1i >= 0 && c1i < len) words[c1i] = 8'(c1v);
  endtask

  // Reference model: scores the words the FIFO will deliver against the ramp.
  task automatic modelBurst(input int len, output int m_err, output int m_fe, output int m_last);
    m_err  = 0;
    m_fe   = 0;
    m_last = 0;
    for (int i = 0; i < len; i++) begin
      if (words[i] != 8'((SEED + i) % 256)) begin
        if (m_err == 0) m_fe = i;
        m_err++;
      end
      m_last = int'(words[i]);
    end
  endtask

  task automatic applyStimulus(input string name, input int len, input int idle,
                               input int st_after, input int st_len, input int restart_at,
                               input int exp_wc, input int exp_err, input int exp_flag,
                               input int exp_fe, input int exp_last, input int exp_dur);
    int dur;
    int limit;
    bit hit;
    int odd;
    int busy_start;
    @(negedge clk);
    fifo_q = words;
    acc_count = 0;
    acc_times.delete();
    ren_viol = 0;
    stall_after_cfg = st_after;
    stall_len_cfg = st_len;
    stall_armed = (st_len > 0);
    @(negedge clk);
    start_s = 1'b1;
    burst_len_s = 11'(len);
    rd_idle_s = 4'(idle);
    @(negedge clk);
    start_s = 1'b0;
    burst_len_s = 11'd3;
    rd_idle_s = 4'd0;
    busy_start = int'(busy_o);
    limit = len * (1 + idle) + st_len + 20;
    dur = 0;
    hit = 1'b0;
    while (!hit && dur < limit) begin
      if (done_o) hit = 1'b1;
      else begin
        start_s = (dur == restart_at);
        @(negedge clk);
        dur++;
      end
    end
    start_s = 1'b0;
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s/timeout: DONE not seen within %0d cycles, expected by %0d", name, limit, exp_dur);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      checkOutput({name, "/duration"}, dur, exp_dur);
      @(negedge clk);
      checkOutput({name, "/done_one_cycle"}, int'(done_o), 0);
      checkOutput({name, "/busy_after"}, int'(busy_o), 0);
    end
    odd = 0;
    for (int i = 1; i < acc_times.size(); i++)
      if (acc_times[i] - acc_times[i-1] != 1 + idle) odd++;
    checkOutput({name, "/busy_at_start"}, busy_start, (len > 0) ? 1 : 0);
    checkOutput({name, "/reads"}, acc_count, len);
    checkOutput({name, "/spacing"}, odd, (st_len > 0) ? 1 : 0);
    checkOutput({name, "/read_while_empty"}, ren_viol, 0);
    checkOutput({name, "/word_cnt"}, int'(wc_o), exp_wc);
    checkOutput({name, "/err_cnt"}, int'(ec_o), exp_err);
    checkOutput({name, "/err_flag"}, int'(ef_o), exp_flag);
    checkOutput({name, "/first_err_idx"}, int'(fe_o), exp_fe);
    checkOutput({name, "/last_data"}, int'(ld_o), exp_last);
  endtask

  initial begin
    int m_err;
    int m_fe;
    int m_last;
    int len;
    int idle;
    int rs;
    int w;

    vecs[0] = '{"clean",       16, 0, -1, 0,    -1, 0,    0, 0, -1, 16,   0, 0, 0, 17};
    vecs[1] = '{"gap",          8, 2, -1, 0,    -1, 0,    0, 0, -1, 8,    0, 0, 0, 23};
    vecs[2] = '{"empty_stall", 10, 0, -1, 0,    -1, 0,    3, 5, -1, 10,   0, 0, 0, 16};
    vecs[3] = '{"corrupt",     12, 0,  4, 8'hAA, 9, 8'h00, 0, 0, -1, 12,   2, 1, 4, 13};
    vecs[4] = '{"zero_len",     0, 0, -1, 0,    -1, 0,    0, 0, -1, 0,    0, 0, 0, 0};
    vecs[5] = '{"corrupt_gap",  5, 3,  0, 8'h55, -1, 0,   0, 0, -1, 5,    1, 1, 0, 18};
    vecs[6] = '{"start_busy",   6, 1, -1, 0,    -1, 0,    0, 0,  3, 6,    0, 0, 0, 12};
    vecs[7] = '{"wrap1024",  1024, 0, -1, 0,    -1, 0,    0, 0, -1, 1024, 0, 0, 0, 1025};

    rst_n = 1'b0;
    start_s = 1'b0;
    burst_len_s = '0;
    rd_idle_s = '0;
    empty_s = 1'b1;
    data_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset/r_en", int'(r_en_o), 0);
    checkOutput("reset/busy", int'(busy_o), 0);
    checkOutput("reset/done", int'(done_o), 0);
    checkOutput("reset/word_cnt", int'(wc_o), 0);
    checkOutput("reset/err_cnt", int'(ec_o), 0);
    checkOutput("reset/err_flag", int'(ef_o), 0);
    checkOutput("reset/first_err_idx", int'(fe_o), 0);
    checkOutput("reset/last_data", int'(ld_o), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      buildWords(vecs[v].len, vecs[v].c0i, vecs[v].c0v, vecs[v].c1i, vecs[v].c1v);
      modelBurst(vecs[v].len, m_err, m_fe, m_last);
      applyStimulus(vecs[v].name, vecs[v].len, vecs[v].idle, vecs[v].st_after, vecs[v].st_len,
                    vecs[v].restart, vecs[v].wc, vecs[v].err, vecs[v].flag, vecs[v].fe,
                    m_last, vecs[v].dur);
    end

    // Reset in the middle of a 20-word burst, then a fresh 4-word burst.
    buildWords(20, -1, 0, -1, 0);
    @(negedge clk);
    fifo_q = words;
    acc_count = 0;
    acc_times.delete();
    stall_armed = 1'b0;
    @(negedge clk);
    start_s = 1'b1;
    burst_len_s = 11'd20;
    rd_idle_s = 4'd0;
    @(negedge clk);
    start_s = 1'b0;
    w = 0;
    while (acc_count < 5 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("rst_mid/reads_before_reset", acc_count, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid/r_en", int'(r_en_o), 0);
    checkOutput("rst_mid/busy", int'(busy_o), 0);
    checkOutput("rst_mid/done", int'(done_o), 0);
    checkOutput("rst_mid/word_cnt", int'(wc_o), 0);
    checkOutput("rst_mid/err_cnt", int'(ec_o), 0);
    checkOutput("rst_mid/err_flag", int'(ef_o), 0);
    checkOutput("rst_mid/first_err_idx", int'(fe_o), 0);
    checkOutput("rst_mid/last_data", int'(ld_o), 0);
    @(negedge clk);
    checkOutput("rst_mid/r_en_later", int'(r_en_o), 0);
    buildWords(4, -1, 0, -1, 0);
    modelBurst(4, m_err, m_fe, m_last);
    applyStimulus("after_reset", 4, 0, 0, 0, -1, 4, m_err, (m_err > 0) ? 1 : 0, m_fe, m_last, 5);

    // Randomized bursts with random corruption, scored by the reference model.
    for (int t = 0; t < 20; t++) begin
      len = $urandom_range(1, 40);
      idle = $urandom_range(0, 3);
      buildWords(len, -1, 0, -1, 0);
      for (int i = 0; i < len; i++)
        if ($urandom_range(0, 7) == 0) words[i] = 8'($urandom);
      rs = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
      modelBurst(len, m_err, m_fe, m_last);
      applyStimulus($sformatf("rand%0d", t), len, idle, 0, 0, rs, len, m_err,
                    (m_err > 0) ? 1 : 0, m_fe, m_last, len * (1 + idle) - idle + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
